// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port between two requesters.
// The winning request is latched for the whole RAM transaction, completion is a
// single DONE cycle back to the owner, and RAM error or BUSY timeout aborts it.
module ram_arbiter #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              tbCTRL,
    input  logic              req0_ren,
    input  logic              req0_wen,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WORD_W-1:0] req0_store,
    output logic              req0_wait,
    output logic [WORD_W-1:0] req0_load,
    output logic              req0_err,
    input  logic              req1_ren,
    input  logic              req1_wen,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WORD_W-1:0] req1_store,
    output logic              req1_wait,
    output logic [WORD_W-1:0] req1_load,
    output logic              req1_err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic [1:0]        ram_state,
    output logic [1:0]        gnt
);

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] BUSY_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              pri_q, pri_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [WORD_W-1:0] load_q, load_d;
    logic [7:0]        busy_cnt_q, busy_cnt_d;

    logic act0, act1, winner, ram_on, done0, done1;

    assign act0   = req0_ren | req0_wen;
    assign act1   = req1_ren | req1_wen;
    // a tie goes to the requester holding priority
    assign winner = (act0 & act1) ? pri_q : act1;

    // next-state and datapath latching
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        pri_d      = pri_q;
        wen_d      = wen_q;
        err_d      = err_q;
        addr_d     = addr_q;
        store_d    = store_q;
        load_d     = load_q;
        busy_cnt_d = busy_cnt_q;
        if (tbCTRL) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act0 | act1) begin
                        owner_d    = winner;
                        wen_d      = winner ? req1_wen   : req0_wen;
                        addr_d     = winner ? req1_addr  : req0_addr;
                        store_d    = winner ? req1_store : req0_store;
                        busy_cnt_d = 8'd0;
                        state_d    = SERVE;
                    end
                end
                SERVE: begin
                    case (ram_state)
                        RAM_ACCESS: begin
                            load_d  = ram_load;
                            err_d   = 1'b0;
                            state_d = DONE;
                        end
                        RAM_ERROR: begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                        RAM_BUSY: begin
                            busy_cnt_d = busy_cnt_q + 8'd1;
                            if (busy_cnt_q == BUSY_LAST) begin
                                err_d   = 1'b1;
                                state_d = DONE;
                            end
                        end
                        RAM_FREE: begin
                            busy_cnt_d = busy_cnt_q;
                        end
                    endcase
                end
                DONE: begin
                    pri_d   = ~owner_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            pri_q      <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            load_q     <= '0;
            busy_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            pri_q      <= pri_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            load_q     <= load_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // RAM side is driven only from latched registers and released under tbCTRL
    assign ram_on    = (state_q == SERVE) & ~tbCTRL;
    assign ram_ren   = ram_on & ~wen_q;
    assign ram_wen   = ram_on & wen_q;
    assign ram_addr  = ram_on ? addr_q  : '0;
    assign ram_store = ram_on ? store_q : '0;
    assign gnt       = ((state_q != IDLE) & ~tbCTRL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // requester side: completion visible only in the owner's DONE cycle
    assign done0     = (state_q == DONE) & ~owner_q;
    assign done1     = (state_q == DONE) & owner_q;
    assign req0_wait = act0 & ~done0;
    assign req1_wait = act1 & ~done1;
    assign req0_load = done0 ? load_q : '0;
    assign req1_load = done1 ? load_q : '0;
    assign req0_err  = done0 & err_q;
    assign req1_err  = done1 & err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, directed corner sequences and random stimulus
// checked against a transaction-level model of the arbiter.
module tb_ram_arbiter;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned OW      = 8 + ADDR_W + 3 * WORD_W;
    localparam int unsigned TW      = 8 + ADDR_W + 2 * WORD_W;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

    logic CLK = 1'b0;
    logic nRST, tbCTRL;
    logic req0_ren, req0_wen, req1_ren, req1_wen;
    logic [ADDR_W-1:0] req0_addr, req1_addr, ram_addr;
    logic [WORD_W-1:0] req0_store, req1_store, ram_store, ram_load, req0_load, req1_load;
    logic req0_wait, req1_wait, req0_err, req1_err, ram_ren, ram_wen;
    logic [1:0] ram_state, gnt;

    always #5 CLK = ~CLK;

    ram_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .tbCTRL(tbCTRL),
        .req0_ren(req0_ren), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_store(req0_store),
        .req0_wait(req0_wait), .req0_load(req0_load), .req0_err(req0_err),
        .req1_ren(req1_ren), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_store(req1_store),
        .req1_wait(req1_wait), .req1_load(req1_load), .req1_err(req1_err),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_state(ram_state), .gnt(gnt)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic              r0, w0;
        logic [ADDR_W-1:0] a0;
        logic              r1, w1;
        logic [ADDR_W-1:0] a1;
        logic [1:0]        rs;
        logic [WORD_W-1:0] rl;
        logic [1:0]        x_gnt;
        logic              x_ren, x_wen;
        logic [ADDR_W-1:0] x_addr;
        logic              x_w0, x_w1;
        logic [WORD_W-1:0] x_l0, x_l1;
        logic              x_e0, x_e1;
    } vec_t;

    vec_t vecs [12];

    // transaction-level reference: who owns the port, what was latched, how it ends
    bit m_serving, m_finishing, m_who, m_tie, m_wr, m_bad;
    int m_stall;
    logic [ADDR_W-1:0] m_a;
    logic [WORD_W-1:0] m_d, m_rd;

    // snapshot of DUT outputs at the last check point
    logic [1:0] s_gnt;
    logic s_ren, s_wen, s_w0, s_w1, s_e0;
    logic [ADDR_W-1:0] s_addr;
    logic [WORD_W-1:0] s_store, s_l0;

    task automatic model_reset();
        m_serving = 0; m_finishing = 0; m_who = 0; m_tie = 0; m_wr = 0; m_bad = 0;
        m_stall = 0; m_a = '0; m_d = '0; m_rd = '0;
    endtask

    function automatic logic [OW-1:0] dut_pack();
        return {gnt, ram_ren, ram_wen, ram_addr, ram_store, req0_wait, req1_wait,
                req0_load, req1_load, req0_err, req1_err};
    endfunction

    function automatic logic [OW-1:0] model_pack();
        bit on = m_serving && !tbCTRL;
        bit f0 = m_finishing && !m_who;
        bit f1 = m_finishing && m_who;
        logic [1:0] g = ((m_serving || m_finishing) && !tbCTRL) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
        logic [ADDR_W-1:0] ea = on ? m_a : ADDR_W'(0);
        logic [WORD_W-1:0] ed = on ? m_d : WORD_W'(0);
        logic [WORD_W-1:0] l0 = f0 ? m_rd : WORD_W'(0);
        logic [WORD_W-1:0] l1 = f1 ? m_rd : WORD_W'(0);
        logic ew0 = (req0_ren | req0_wen) && !f0;
        logic ew1 = (req1_ren | req1_wen) && !f1;
        logic ee0 = f0 && m_bad;
        logic ee1 = f1 && m_bad;
        logic er  = on && !m_wr;
        logic ewr = on && m_wr;
        return {g, er, ewr, ea, ed, ew0, ew1, l0, l1, ee0, ee1};
    endfunction

    // advance the reference by one clock using the inputs sampled at that edge
    task automatic model_step();
        bit a0 = req0_ren | req0_wen;
        bit a1 = req1_ren | req1_wen;
        if (tbCTRL) begin
            m_serving = 0; m_finishing = 0;
        end else if (m_finishing) begin
            m_tie = !m_who; m_finishing = 0;
        end else if (m_serving) begin
            if (ram_state == RS_ACC) begin
                m_rd = ram_load; m_bad = 0; m_serving = 0; m_finishing = 1;
            end else if (ram_state == RS_ERR) begin
                m_bad = 1; m_serving = 0; m_finishing = 1;
            end else if (ram_state == RS_BUSY) begin
                m_stall++;
                if (m_stall == int'(TIMEOUT)) begin
                    m_bad = 1; m_serving = 0; m_finishing = 1;
                end
            end
        end else if (a0 || a1) begin
            m_who = (a0 && a1) ? m_tie : a1;
            m_wr  = m_who ? req1_wen : req0_wen;
            m_a   = m_who ? req1_addr : req0_addr;
            m_d   = m_who ? req1_store : req0_store;
            m_stall = 0;
            m_serving = 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic check_vec(input int i);
        logic [TW-1:0] act, exp;
        act = {gnt, ram_ren, ram_wen, ram_addr, req0_wait, req1_wait, req0_load, req1_load, req0_err, req1_err};
        exp = {vecs[i].x_gnt, vecs[i].x_ren, vecs[i].x_wen, vecs[i].x_addr, vecs[i].x_w0, vecs[i].x_w1,
               vecs[i].x_l0, vecs[i].x_l1, vecs[i].x_e0, vecs[i].x_e1};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec[%0d]: got %h want %h", i, act, exp);
        end
    endtask

    // one clock: check at negedge, step the reference, return just after posedge
    task automatic cycle(input int vec_idx);
        logic [OW-1:0] act, exp;
        @(negedge CLK);
        if (vec_idx >= 0) check_vec(vec_idx);
        act = dut_pack();
        exp = model_pack();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model cyc %0d: got %h want %h", cyc, act, exp);
        end
        s_gnt = gnt; s_ren = ram_ren; s_wen = ram_wen; s_addr = ram_addr; s_store = ram_store;
        s_w0 = req0_wait; s_w1 = req1_wait; s_l0 = req0_load; s_e0 = req0_err;
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        tbCTRL = 0; req0_ren = 0; req0_wen = 0; req1_ren = 0; req1_wen = 0;
        req0_addr = '0; req1_addr = '0; req0_store = '0; req1_store = '0;
        ram_state = RS_FREE; ram_load = '0;
    endtask

    task automatic do_reset();
        nRST = 0;
        idle_inputs();
        #2;
        model_reset();
        n_cmp++;
        if (dut_pack() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", dut_pack());
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    task automatic run_table();
        vecs[0]  = '{1'b1,1'b0,32'h44,1'b0,1'b0,32'h0,RS_FREE,32'h0,         2'b00,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,32'h44,1'b0,1'b0,32'h0,RS_ERR,32'h0,          2'b01,1'b1,1'b0,32'h44,1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,32'h44,1'b0,1'b0,32'h0,RS_FREE,32'h0,         2'b01,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,32'h48,1'b1,1'b0,32'h80,RS_FREE,32'h0,        2'b00,1'b0,1'b0,32'h0, 1'b1,1'b1,32'h0,32'h0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,32'h48,1'b1,1'b0,32'h84,RS_ACC,32'hCAFEF00D,  2'b10,1'b1,1'b0,32'h80,1'b1,1'b1,32'h0,32'h0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,32'h48,1'b1,1'b0,32'h84,RS_FREE,32'h0,        2'b10,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'hCAFEF00D,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,32'h40,1'b0,1'b0,32'h0,RS_FREE,32'h0,         2'b00,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,32'h40,1'b0,1'b0,32'h0,RS_BUSY,32'h0,         2'b01,1'b1,1'b0,32'h40,1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,32'h40,1'b0,1'b0,32'h0,RS_BUSY,32'h0,         2'b01,1'b1,1'b0,32'h40,1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,32'h40,1'b0,1'b0,32'h0,RS_ACC,32'hDEADBEEF,   2'b01,1'b1,1'b0,32'h40,1'b1,1'b0,32'h0,32'h0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,32'h40,1'b0,1'b0,32'h0,RS_FREE,32'h0,         2'b01,1'b0,1'b0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,RS_FREE,32'h0,          2'b00,1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,1'b0,1'b0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req0_ren = vecs[i].r0; req0_wen = vecs[i].w0; req0_addr = vecs[i].a0;
            req1_ren = vecs[i].r1; req1_wen = vecs[i].w1; req1_addr = vecs[i].a1;
            ram_state = vecs[i].rs; ram_load = vecs[i].rl;
            cycle(i);
        end
    endtask

    task automatic run_contention();
        int dn = 0;
        int own [4];
        int at [4];
        do_reset();
        req0_ren = 1; req1_ren = 1; req0_addr = 32'h10; req1_addr = 32'h20; ram_state = RS_ACC;
        for (int c = 0; c < 13; c++) begin
            ram_load = $urandom;
            cycle(-1);
            if (s_gnt != 2'b00 && (!s_w0 || !s_w1) && dn < 4) begin
                own[dn] = int'(s_gnt[1]); at[dn] = c; dn++;
            end
        end
        chk("contention_done_count", 64'(dn), 64'd4);
        for (int i = 0; i < dn; i++) begin
            chk("contention_owner", 64'(own[i]), 64'(i % 2));
            if (i == 0) chk("contention_first_done", 64'(at[0]), 64'd2);
            else chk("contention_spacing", 64'(at[i] - at[i-1]), 64'd3);
        end
        idle_inputs();
        cycle(-1);
    endtask

    task automatic run_write_prio();
        do_reset();
        req1_ren = 1; req1_wen = 1; req1_addr = 32'h80; req1_store = 32'h1234; ram_state = RS_BUSY;
        cycle(-1);
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) req1_addr = 32'h99;
            ram_state = (c == 4) ? RS_ACC : RS_BUSY;
            cycle(-1);
            chk("wprio_ram_wen", 64'(s_wen), 64'd1);
            chk("wprio_ram_ren", 64'(s_ren), 64'd0);
            chk("wprio_ram_store", 64'(s_store), 64'h1234);
            chk("wprio_ram_addr", 64'(s_addr), 64'h80);
        end
        ram_state = RS_FREE;
        cycle(-1);
        chk("wprio_done_wait1", 64'(s_w1), 64'd0);
        idle_inputs();
        cycle(-1);
    endtask

    task automatic run_timeout();
        int strobes = 0;
        int done_at = -1;
        do_reset();
        req0_ren = 1; req0_addr = 32'h60; ram_state = RS_BUSY;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            cycle(-1);
            if (s_ren) strobes++;
            if (s_gnt == 2'b01 && !s_w0) begin
                done_at = c;
                chk("timeout_err", 64'(s_e0), 64'd1);
                chk("timeout_strobes_drop", 64'({s_ren, s_wen}), 64'd0);
            end
        end
        idle_inputs();
        chk("timeout_done_cycle", 64'(done_at), 64'd16);
        chk("timeout_busy_cycles", 64'(strobes), 64'd15);
        cycle(-1);
    endtask

    task automatic run_tbctrl();
        do_reset();
        req0_ren = 1; req0_addr = 32'h70; ram_state = RS_FREE;
        cycle(-1); cycle(-1); cycle(-1);
        chk("tbctrl_pre_gnt", 64'(s_gnt), 64'd1);
        tbCTRL = 1;
        for (int c = 0; c < 3; c++) begin
            cycle(-1);
            chk("tbctrl_ram_strobes", 64'({s_ren, s_wen}), 64'd0);
            chk("tbctrl_ram_addr", 64'(s_addr), 64'd0);
            chk("tbctrl_ram_store", 64'(s_store), 64'd0);
            chk("tbctrl_gnt", 64'(s_gnt), 64'd0);
            chk("tbctrl_wait0", 64'(s_w0), 64'd1);
            chk("tbctrl_no_done", 64'({s_l0, s_e0}), 64'd0);
        end
        tbCTRL = 0; req1_ren = 1; req1_addr = 32'h74;
        cycle(-1);
        chk("tbctrl_rearb_idle_gnt", 64'(s_gnt), 64'd0);
        chk("tbctrl_rearb_idle_wait0", 64'(s_w0), 64'd1);
        cycle(-1);
        chk("tbctrl_rearb_owner", 64'(s_gnt), 64'd1);
        chk("tbctrl_rearb_addr", 64'(s_addr), 64'h70);
        idle_inputs();
        cycle(-1);
    endtask

    task automatic run_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                req0_ren = 1'($urandom_range(0, 1)); req0_wen = 1'($urandom_range(0, 1));
                req0_addr = ADDR_W'($urandom); req0_store = WORD_W'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                req1_ren = 1'($urandom_range(0, 1)); req1_wen = 1'($urandom_range(0, 1));
                req1_addr = ADDR_W'($urandom); req1_store = WORD_W'($urandom);
            end
            ram_state = ((n % 400) < 30) ? RS_BUSY : 2'($urandom_range(0, 3));
            ram_load  = WORD_W'($urandom);
            tbCTRL    = ($urandom_range(0, 31) == 0);
            cycle(-1);
        end
    endtask

    initial begin
        run_table();
        run_contention();
        run_write_prio();
        run_timeout();
        run_tbctrl();
        run_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
